// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: prefetches framebuffer words from video memory and replicates them
// horizontally and vertically to feed the VGA timing stage one pixel word per active cycle.
module vga_pixel_fetch #(
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          H_SCALE      = 8,
    parameter int          V_SCALE      = 8,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] BASE_DEFAULT = 16'hC000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        active,
    input  logic        vsync,
    input  logic [15:0] base_addr,
    input  logic        base_load,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic [15:0] img_reg,
    output logic        underrun,
    input  logic        underrun_clr
);
    localparam int WPL = H_ACTIVE / H_SCALE;
    localparam int CW  = $clog2(WPL + 1);
    localparam int RW  = $clog2(V_SCALE + 1);
    localparam int LW  = $clog2(V_ACTIVE + 1);
    localparam int PW  = $clog2(H_SCALE + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

    state_t        state_q, state_d;
    logic          vsync_q, armed_q, drop_q, drop_d, ur_q, ur_d;
    logic [15:0]   shadow_q, addr_q, addr_d, row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [LW-1:0] line_q, line_d;
    logic [PW-1:0] px_q, px_d;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [15:0]   fifo_q [FIFO_DEPTH];
    logic          fs, acc, eol, last_rep, done, empty, pop;

    always_comb begin
        fs       = vsync_q & ~vsync;
        acc      = (state_q == WAIT) & mem_valid & ~fs;
        eol      = col_q == CW'(WPL - 1);
        last_rep = rep_q == RW'(V_SCALE - 1);
        done     = eol & (line_q == LW'(V_ACTIVE - 1));
        empty    = cnt_q == '0;
        pop      = active & (px_q == PW'(H_SCALE - 1)) & ~empty;
        px_d     = active ? ((px_q == PW'(H_SCALE - 1)) ? '0 : px_q + 1'b1) : '0;
        ur_d     = (active & armed_q & empty) | (ur_q & ~underrun_clr);
        // a response still in flight at frame start belongs to the old frame
        drop_d   = (drop_q & ~mem_valid) | (fs & (state_q == WAIT) & ~mem_valid);
        state_d  = state_q;
        addr_d   = addr_q;
        row_d    = row_q;
        col_d    = col_q;
        rep_d    = rep_q;
        line_d   = line_q;
        if (fs) begin
            state_d = FETCH;
            addr_d  = shadow_q;
            row_d   = shadow_q;
            col_d   = '0;
            rep_d   = '0;
            line_d  = '0;
        end else if (state_q == FETCH && !drop_q && cnt_q < DEPTH) begin
            state_d = WAIT;
        end else if (acc) begin
            col_d   = eol ? '0 : col_q + 1'b1;
            line_d  = eol ? line_q + 1'b1 : line_q;
            rep_d   = eol ? (last_rep ? '0 : rep_q + 1'b1) : rep_q;
            row_d   = (eol && last_rep) ? row_q + 16'(WPL) : row_q;
            addr_d  = !eol ? addr_q + 16'd1 : (last_rep ? row_q + 16'(WPL) : row_q);
            // keep mem_req high for back-to-back reads while room remains after this push
            state_d = done ? IDLE : (cnt_q < DEPTH - 1'b1) ? WAIT : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vsync_q  <= 1'b0;
            armed_q  <= 1'b0;
            drop_q   <= 1'b0;
            ur_q     <= 1'b0;
            shadow_q <= BASE_DEFAULT;
            addr_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            rep_q    <= '0;
            line_q   <= '0;
            px_q     <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            vsync_q  <= vsync;
            armed_q  <= armed_q | fs;
            drop_q   <= drop_d;
            ur_q     <= ur_d;
            shadow_q <= base_load ? base_addr : shadow_q;
            addr_q   <= addr_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rep_q    <= rep_d;
            line_q   <= line_d;
            px_q     <= px_d;
            wr_q     <= fs ? '0 : wr_q + AW'(acc);
            rd_q     <= fs ? '0 : rd_q + AW'(pop);
            cnt_q    <= fs ? '0 : cnt_q + (AW+1)'(acc) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (acc) fifo_q[wr_q] <= mem_rdata;

    assign mem_req  = state_q == WAIT;
    assign mem_addr = addr_q;
    assign img_reg  = empty ? 16'h0000 : fifo_q[rd_q];
    assign underrun = ur_q;
endmodule
